// File: rtl/safe_cracker_if.sv
// rtl/safe_cracker_if.sv - code-entry link between the cracker (master) and the safe (slave)
interface safe_cracker_if #(
  parameter int W  = 10,
  parameter int HW = 4
);
  logic [W-1:0]  guess;
  logic          enter;
  logic [HW-1:0] hint;
  logic          locked;

  modport master (output guess, output enter, input hint, input locked);
  modport slave  (input guess, input enter, output hint, output locked);
endinterface

// File: rtl/safe_cracker.sv
// rtl/safe_cracker.sv - recovers the safe password bit by bit from Hamming-distance hints
module safe_cracker #(
  parameter int W            = 10,
  parameter int HW           = 4,
  parameter int SETTLE       = 2,
  parameter int ENTER_CYCLES = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                   clk,
  input  logic                   RESETN,
  input  logic                   start,
  safe_cracker_if.master         safe,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [$clog2(W+2)-1:0] probes
);
  localparam int PW   = $clog2(W + 2);
  localparam int IW   = (W > 1) ? $clog2(W) : 1;
  localparam int HX   = HW + 1;
  localparam int CMAX = (SETTLE > ENTER_CYCLES)
                        ? ((SETTLE > TIMEOUT) ? SETTLE : TIMEOUT)
                        : ((ENTER_CYCLES > TIMEOUT) ? ENTER_CYCLES : TIMEOUT);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETTLE_C     = CW'(SETTLE);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] ENTER_LAST   = CW'(ENTER_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [HX-1:0] W_X          = HX'(W);
  localparam logic [IW-1:0] IDX_LAST     = IW'(W - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_BASE, S_FLIP, S_WAIT, S_EVAL, S_SUBMIT, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t        state;
  logic [W-1:0]  guess_q;
  logic          enter_q;
  logic [IW-1:0] idx;
  logic [HW-1:0] best;
  logic [CW-1:0] cnt;

  logic [HX-1:0] h_x, best_m1, best_p1;
  logic          hint_bad, keep, revert;
  logic [HW-1:0] best_after;
  logic [PW-1:0] probes_inc;

  assign safe.guess = guess_q;
  assign safe.enter = enter_q;

  // Hint arithmetic is done one bit wider so best+1 cannot wrap at the top of the range.
  assign h_x        = {1'b0, safe.hint};
  assign best_m1    = {1'b0, best} - HX'(1);
  assign best_p1    = {1'b0, best} + HX'(1);
  assign hint_bad   = (h_x > W_X);
  assign keep       = (h_x == best_m1);
  assign revert     = (h_x == best_p1);
  assign best_after = keep ? safe.hint : best;
  assign probes_inc = (probes == '1) ? probes : probes + PW'(1);

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      state   <= S_IDLE;
      guess_q <= '0;
      enter_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      probes  <= '0;
      idx     <= '0;
      best    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            guess_q <= '0;
            done    <= 1'b0;
            fail    <= 1'b0;
            probes  <= '0;
            idx     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_BASE;
          end
        end
        S_BASE: begin
          if (cnt != SETTLE_C) begin
            cnt <= cnt + CW'(1);
          end else begin
            probes <= probes_inc;
            best   <= safe.hint;
            cnt    <= '0;
            if (hint_bad) begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FAIL;
            end else if (safe.hint == '0) begin
              enter_q <= 1'b1;
              state   <= S_SUBMIT;
            end else begin
              state <= S_FLIP;
            end
          end
        end
        S_FLIP: begin
          guess_q[idx] <= ~guess_q[idx];
          cnt          <= '0;
          state        <= (SETTLE == 0) ? S_EVAL : S_WAIT;
        end
        S_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_EVAL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EVAL: begin
          probes <= probes_inc;
          // A single flipped bit can only move the distance by exactly one.
          if (hint_bad || !(keep || revert)) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            if (revert) guess_q[idx] <= ~guess_q[idx];
            best <= best_after;
            if (best_after == '0) begin
              enter_q <= 1'b1;
              cnt     <= '0;
              state   <= S_SUBMIT;
            end else if (idx == IDX_LAST) begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FAIL;
            end else begin
              idx   <= idx + IW'(1);
              state <= S_FLIP;
            end
          end
        end
        S_SUBMIT: begin
          if (cnt == ENTER_LAST) begin
            enter_q <= 1'b0;
            cnt     <= '0;
            state   <= S_CHECK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CHECK: begin
          if (!safe.locked) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_safe_cracker.sv
// tb/tb_safe_cracker.sv - table-driven and randomized checks of safe_cracker against a safe model
module tb_safe_cracker;
  localparam int W  = 10;
  localparam int HW = 4;
  localparam int PW = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          RESETN = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [PW-1:0] probes;

  logic [W-1:0]  pw = '0;
  bit            stuck = 1'b0;
  logic          unlocked = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  safe_cracker_if #(.W(W), .HW(HW)) sif ();

  safe_cracker #(.W(W), .HW(HW), .SETTLE(2), .ENTER_CYCLES(4), .TIMEOUT(16)) dut (
    .clk    (clk),
    .RESETN (RESETN),
    .start  (start),
    .safe   (sif.master),
    .busy   (busy),
    .done   (done),
    .fail   (fail),
    .probes (probes)
  );

  always #5 clk = ~clk;

  // Safe: registered Hamming-distance hint; unlocks one cycle after Enter with the right word.
  always @(posedge clk) begin
    sif.hint <= HW'($countones(sif.guess ^ pw));
    if (!RESETN || start) unlocked <= 1'b0;
    else if (sif.enter && sif.guess == pw && !stuck) unlocked <= 1'b1;
  end
  assign sif.locked = ~unlocked;

  typedef struct {
    logic [W-1:0] pw;
    bit           stuck;
    logic [W-1:0] e_guess;
    bit           e_done;
    bit           e_fail;
    int           e_probes;
    int           e_post;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: bits are searched LSB first until the distance hits zero, so the
  // run samples once for the base plus once per bit up to the highest set bit.
  function automatic int model_probes(input logic [W-1:0] p);
    int msb = -1;
    for (int b = 0; b < W; b++) if (p[b]) msb = b;
    return msb + 2;
  endfunction

  function automatic vec_t model_vec(input logic [W-1:0] p, input bit s);
    vec_t v;
    v.pw       = p;
    v.stuck    = s;
    v.e_guess  = p;
    v.e_done   = !s;
    v.e_fail   = s;
    v.e_probes = model_probes(p);
    v.e_post   = s ? 16 : 1;
    return v;
  endfunction

  task automatic pulse_start(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, busy, 1);
  endtask

  task automatic wait_finish(input string name, output int en_cnt, output int post,
                             output logic [W-1:0] touched, output bit both);
    bit finished = 1'b0;
    bit seen_enter = 1'b0;
    en_cnt = 0; post = 0; touched = '0; both = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      touched |= sif.guess;
      if (done && fail) both = 1'b1;
      if (sif.enter) begin
        en_cnt++;
        seen_enter = 1'b1;
      end
      if (done || fail) begin
        finished = 1'b1;
        break;
      end
      if (seen_enter && !sif.enter) post++;
    end
    check({name, "_finished"}, finished, 1);
  endtask

  task automatic wait_guess(input string name, input logic [W-1:0] val);
    bit hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sif.guess == val) begin
        hit = 1'b1;
        break;
      end
    end
    check({name, "_reached_guess"}, hit, 1);
  endtask

  initial begin
    int           en_cnt, post;
    logic [W-1:0] touched;
    bit           both;
    logic [W-1:0] r;
    longint       mask;

    repeat (2) @(negedge clk);
    check("reset_guess", sif.guess, 0);
    check("reset_enter", sif.enter, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_fail", fail, 0);
    check("reset_probes", probes, 0);
    RESETN = 1'b1;

    tbl.push_back('{10'h2A5, 1'b0, 10'h2A5, 1'b1, 1'b0, 11, 1});
    tbl.push_back('{10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 1, 1});
    tbl.push_back('{10'h001, 1'b0, 10'h001, 1'b1, 1'b0, 2, 1});
    tbl.push_back('{10'h3FF, 1'b0, 10'h3FF, 1'b1, 1'b0, 11, 1});
    tbl.push_back('{10'h155, 1'b1, 10'h155, 1'b0, 1'b1, 10, 16});
    for (int i = 0; i < 10; i++) begin
      r = W'($urandom);
      tbl.push_back(model_vec(r, (i % 4) == 3));
    end

    foreach (tbl[i]) begin
      string n;
      n = $sformatf("v%0d_pw%0h", i, tbl[i].pw);
      pw    = tbl[i].pw;
      stuck = tbl[i].stuck;
      pulse_start(n);
      wait_finish(n, en_cnt, post, touched, both);
      mask = (longint'(1) << (model_probes(tbl[i].pw) - 1)) - 1;
      check({n, "_guess"}, sif.guess, tbl[i].e_guess);
      check({n, "_done"}, done, tbl[i].e_done);
      check({n, "_fail"}, fail, tbl[i].e_fail);
      check({n, "_probes"}, probes, tbl[i].e_probes);
      check({n, "_busy_end"}, busy, 0);
      check({n, "_enter_cycles"}, en_cnt, 4);
      check({n, "_check_cycles"}, post, tbl[i].e_post);
      check({n, "_untouched_bits"}, longint'(touched) & ~mask, 0);
      check({n, "_done_and_fail"}, both, 0);
    end

    // Password changes while bit 3 is settling: the hint jumps by more than one.
    pw = 10'h2A5; stuck = 1'b0;
    pulse_start("jump");
    wait_guess("jump", 10'h00D);
    pw = 10'h35A;
    wait_finish("jump", en_cnt, post, touched, both);
    check("jump_fail", fail, 1);
    check("jump_done", done, 0);
    check("jump_guess", sif.guess, 10'h00D);
    check("jump_probes", probes, 5);
    check("jump_busy", busy, 0);
    check("jump_enter", en_cnt, 0);

    // Second start while busy must be ignored.
    pw = 10'h3FF;
    pulse_start("reject");
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (probes == PW'(3)) begin
          hit = 1'b1;
          break;
        end
      end
      check("reject_reached_probes3", hit, 1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("reject_probes_kept", probes >= PW'(3), 1);
    check("reject_still_busy", busy, 1);
    wait_finish("reject", en_cnt, post, touched, both);
    check("reject_guess", sif.guess, 10'h3FF);
    check("reject_probes", probes, 11);
    check("reject_done", done, 1);

    // Asynchronous reset in the middle of a settle wait.
    pw = 10'h2A5;
    pulse_start("midrst");
    wait_guess("midrst", 10'h00D);
    #2;
    RESETN = 1'b0;
    #1;
    check("midrst_guess", sif.guess, 0);
    check("midrst_enter", sif.enter, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_fail", fail, 0);
    check("midrst_probes", probes, 0);
    repeat (2) @(negedge clk);
    RESETN = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_guess", sif.guess, 0);
    check("idle_probes", probes, 0);

    pw = 10'h3FF;
    pulse_start("after_rst");
    wait_finish("after_rst", en_cnt, post, touched, both);
    check("after_rst_guess", sif.guess, 10'h3FF);
    check("after_rst_probes", probes, 11);
    check("after_rst_done", done, 1);
    check("after_rst_fail", fail, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/safe_cracker.md
Name: safe_cracker

Overview:
- Automatic code breaker that sits on the opposite side of the safe's code-entry interface.
- Drives the safe's switch word (`guess`) and reads back the safe's Hamming-distance hint, which is the count of mismatched bits.
- Recovers the password one bit at a time, then presses Enter and confirms that the safe unlocks.
- Used as a self-test and demo master in place of the switches and keys.

Parameters:
- W, 10: width of the password and guess word.
- HW, 4: width of `hint`; must be at least clog2(W+1).
- SETTLE, 2: cycles waited after every `guess` change before `hint` is sampled; covers the safe's hint latency.
- ENTER_CYCLES, 4: number of cycles `enter` is held high per submission.
- TIMEOUT, 16: cycles allowed after `enter` falls for `locked` to deassert.

Ports:
- clk, input, 1: system clock.
- RESETN, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request to begin cracking.
- hint, input, HW: safe's popcount(guess XOR password).
- locked, input, 1: safe status; 1 = locked.
- guess, output, W: word presented to the safe as its switch inputs.
- enter, output, 1: Enter press to the safe, active high.
- busy, output, 1: high from the cycle after an accepted `start` until DONE or FAIL.
- done, output, 1: sticky; the safe opened.
- fail, output, 1: sticky; inconsistent hint or timeout.
- probes, output, clog2(W+2): number of hint samples taken in the current run.

Behaviour:
- Reset (asynchronous on RESETN low; takes effect mid-operation too): state=IDLE, guess=0, enter=0, busy=0, done=0, fail=0, probes=0, idx=0, best=0. Internal counters are cleared.
- All outputs are registered.
- `start` is accepted only in IDLE, DONE or FAIL. It is ignored while `busy`=1.
- On acceptance (edge N):
  - guess<=0, done<=0, fail<=0, probes<=0, idx<=0, state<=BASE.
  - `busy`=1 from cycle N+1.
- BASE:
  - Wait SETTLE cycles, then sample `hint` into `best`; probes+1.
  - If best=0, go to SUBMIT. Otherwise go to FLIP.
- FLIP: guess[idx] is inverted (one cycle); state<=WAIT.
- WAIT: counts SETTLE cycles, then goes to EVAL.
- EVAL samples `hint` as h; probes+1.
  - h=best-1: keep the flip; best<=h.
  - h=best+1: revert guess[idx].
  - Any other h: go to FAIL; guess is left as-is.
  - Next state:
    - best (after update) = 0: go to SUBMIT, skipping the remaining bits.
    - Otherwise, if idx=W-1: go to FAIL, since the search completed but the hint is nonzero.
    - Otherwise: idx+1 and go to FLIP.
  - Bits are visited LSB first.
- SUBMIT: `enter`=1 for exactly ENTER_CYCLES consecutive cycles, then goes to CHECK.
- CHECK:
  - Each cycle: if locked=0, go to DONE.
  - If TIMEOUT cycles elapse with locked=1, go to FAIL.
- DONE: done=1, busy=0. `guess` holds the recovered password.
- FAIL: fail=1, busy=0. `guess` holds its last value.
- Width rules:
  - `probes` saturates at 2^width-1 and never wraps. The maximum legitimate value is W+1.
  - `hint` above W is treated as an inconsistent sample and goes to FAIL.
- `enter` is never high outside SUBMIT. `done` and `fail` are never both high.

Test Plan:
- Model safe with hint = popcount(guess^pw), registered one cycle, and locked deasserting one cycle after an enter pulse while hint=0.
- pw=10'h2A5, pulse start:
  - guess converges to 10'h2A5.
  - enter is high for 4 cycles.
  - done=1, fail=0, probes=11 (base + 10 bits).
- pw=10'h000:
  - BASE reads 0, goes straight to SUBMIT.
  - probes=1, guess=0, done=1.
- pw=10'h001:
  - Early termination after bit 0.
  - probes=2, guess=10'h001, done=1.
  - guess bits 9:1 never toggle.
- Safe model keeps locked=1 permanently, pw=10'h155:
  - guess=10'h155.
  - enter pulse, then exactly 16 CHECK cycles, then fail=1, done=0, busy=0.
- Change pw 10'h2A5 -> 10'h35A while in WAIT for idx=3, so the hint jumps by more than 1 → fail=1 on that EVAL.
- Reset and start guard:
  - Pulse start again while busy: no effect, and probes is not reset.
  - Drop RESETN mid-WAIT: all outputs are 0 asynchronously, state=IDLE.
  - After release, a new start recovers pw=10'h3FF with probes=11.
